carry_skip_pipe_stage: RTL and testbench
========================================

Name: carry_skip_pipe_stage

Overview:
Two-stage valid/ready pipeline wrapping the carry_skip_generic N-bit adder.
- Stage A registers operands and carry-in, then drives the adder directly.
- Stage B captures sum/cout for a downstream consumer.
- Decouples adder combinational delay from surrounding logic; sustains one addition per cycle under backpressure.

Parameters:
N, 64, operand width; power of 2, >= 16, multiple of 4 (adder block size)

Ports:
clk  input  1  clock, rising-edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  operand beat valid
in_ready  output  1  stage A can accept a beat this cycle
in_a  input  N  operand A
in_b  input  N  operand B
in_cin  input  1  carry-in
out_valid  output  1  result beat valid
out_ready  input  1  consumer accepts result this cycle
out_sum  output  N  registered sum
out_cout  output  1  registered carry-out

Behaviour:
- Reset (async assert, sync release):
  - a_vld=0, b_vld=0, out_valid=0.
  - out_sum=0, out_cout=0, operand registers=0.
  - in_ready reads 1 once reset deasserts.
- Handshakes:
  - Input transfer: in_valid && in_ready at a rising edge.
  - Output transfer: out_valid && out_ready at a rising edge.
  - in_valid must not depend on in_ready; out_valid never depends on out_ready.
- Stage B:
  - b_en = !b_vld || out_ready.
  - When b_en: b_vld <= a_vld; if a_vld, capture adder sum/cout.
  - out_valid = b_vld.
  - out_sum/out_cout hold stable while out_valid && !out_ready.
- Stage A:
  - a_en = !a_vld || b_en; in_ready = a_en (combinational).
  - When a_en: a_vld <= in_valid; if in_valid, load in_a/in_b/in_cin.
  - Registers hold while !a_en.
- Latency: accepted beat appears on out_valid exactly 2 cycles later when no backpressure.
- Throughput: 1 beat/cycle with out_ready held high.
- Capacity: 2 beats in flight; with out_ready=0, in_ready falls after 2 accepted beats.
- Simultaneous events:
  - Full pipe + out_ready=1 + in_valid=1: pop B, shift A->B, load A, all on the same edge; no bubble.
  - Bubbles (a_vld=0) collapse: B may accept from A while A reloads.
- Arithmetic: {out_cout, out_sum} = in_a + in_b + in_cin, unsigned, modulo 2^(N+1). Wrap-around carries into out_cout only.
- Reset mid-operation: all in-flight beats dropped, none presented afterwards; data registers cleared.
- Ordering: results leave strictly in acceptance order.

Optional Feature:
- Macro: CARRY_SKIP_PIPE_SUB_EN.
- Defined:
  - Adds input port in_sub (1 bit), registered in stage A with operands.
  - When in_sub=1: adder gets ~b and carry-in 1; in_cin is ignored.
  - out_cout=1 means no borrow.
  - Example: 5-7 at N=16 gives out_sum=16'hFFFE, out_cout=0.
- Undefined: port absent; pure addition only.

Decomposition:
- Package carry_skip_pkg:
  - CS_BLOCK_W=4.
  - Default width constant CS_N_DEFAULT=64.
  - Function/constant for block count (N/CS_BLOCK_W).
- One sub-module: existing carry_skip_generic, instantiated once between stages A and B.
- No further split; pipeline control is a few flops and two enables.

Test Plan:
1. Reset then single beat, N=64: a=64'hFFFF_FFFF_FFFF_FFFF, b=1, cin=0, out_ready=1 -> out_valid 2 cycles after accept, out_sum=0, out_cout=1.
2. Streaming: 100 random beats, in_valid=1, out_ready=1 -> in_ready stays 1, results match golden model in order, one per cycle.
3. Backpressure: out_ready=0, offer 3 beats (a=1,2,3; b=10; cin=0) -> only 2 accepted, in_ready=0 and out_sum=11 stable; raise out_ready -> 11, 12, 13 emitted, third beat then accepted.
4. Simultaneous pop/push: full pipe, out_ready=1, in_valid=1 for one cycle -> exactly one out transfer and one in transfer on the same edge, no loss or duplication.
5. Reset mid-operation: 2 beats in flight, assert rst for 1 cycle -> out_valid=0 immediately (async), no stale result after release; next beat a=7, b=8, cin=1 -> out_sum=16.
6. With CARRY_SKIP_PIPE_SUB_EN, N=16: a=5, b=7, in_sub=1 -> out_sum=16'hFFFE, out_cout=0; a=9, b=4, in_sub=1 -> out_sum=5, out_cout=1.

Source files
------------

// File: rtl/carry_skip_pkg.sv
// Shared constants for the carry-skip adder and its pipeline wrapper.
//   CS_BLOCK_W    : width of one carry-skip block
//   CS_N_DEFAULT  : default operand width
//   cs_num_blocks : number of skip blocks for an n-bit adder
package carry_skip_pkg;

  localparam int unsigned CS_BLOCK_W   = 4;
  localparam int unsigned CS_N_DEFAULT = 64;

  function automatic int unsigned cs_num_blocks(input int unsigned n);
    return n / CS_BLOCK_W;
  endfunction

endpackage

// File: rtl/carry_skip_generic.sv
// Combinational N-bit carry-skip adder built from CS_BLOCK_W-bit ripple blocks.
// Ports:
//   a, b : operands (N bits)
//   cin  : carry-in
//   sum  : a + b + cin, low N bits
//   cout : carry-out
module carry_skip_generic
  import carry_skip_pkg::*;
#(
  parameter int unsigned N = CS_N_DEFAULT
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  localparam int unsigned NumBlocks = cs_num_blocks(N);

  logic c;      // carry entering the current block
  logic blk_c;  // rippling carry inside the block
  logic prop;   // every bit of the block propagates

  always_comb begin
    sum   = '0;
    c     = cin;
    blk_c = 1'b0;
    prop  = 1'b0;
    for (int k = 0; k < NumBlocks; k++) begin
      blk_c = c;
      prop  = 1'b1;
      for (int i = 0; i < CS_BLOCK_W; i++) begin
        sum[k*CS_BLOCK_W+i] = a[k*CS_BLOCK_W+i] ^ b[k*CS_BLOCK_W+i] ^ blk_c;
        blk_c = (a[k*CS_BLOCK_W+i] & b[k*CS_BLOCK_W+i]) |
                ((a[k*CS_BLOCK_W+i] ^ b[k*CS_BLOCK_W+i]) & blk_c);
        prop  = prop & (a[k*CS_BLOCK_W+i] ^ b[k*CS_BLOCK_W+i]);
      end
      // A fully propagating block passes its incoming carry straight through.
      c = prop ? c : blk_c;
    end
    cout = c;
  end

endmodule

// File: rtl/carry_skip_pipe_stage.sv
// Two-stage valid/ready pipeline around carry_skip_generic.
// Stage A registers operands and drives the adder; stage B registers sum/cout.
// Optional macro CARRY_SKIP_PIPE_SUB_EN adds in_sub (a - b when set).
// Ports:
//   clk, rst             : clock, async active-high reset
//   in_valid / in_ready  : input handshake
//   in_a, in_b, in_cin   : operands and carry-in
//   in_sub               : subtract select (only with CARRY_SKIP_PIPE_SUB_EN)
//   out_valid / out_ready: output handshake
//   out_sum, out_cout    : registered result
module carry_skip_pipe_stage
  import carry_skip_pkg::*;
#(
  parameter int unsigned N = CS_N_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  input  logic         in_cin,
`ifdef CARRY_SKIP_PIPE_SUB_EN
  input  logic         in_sub,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_sum,
  output logic         out_cout
);

  logic         a_vld, b_vld;
  logic         a_en, b_en;
  logic [N-1:0] a_a, a_b;
  logic         a_cin;
  logic [N-1:0] b_sum;
  logic         b_cout;

  logic [N-1:0] add_b;
  logic         add_cin;
  logic [N-1:0] add_sum;
  logic         add_cout;

  // B moves when empty or being drained; A moves when empty or B moves.
  assign b_en     = !b_vld || out_ready;
  assign a_en     = !a_vld || b_en;
  assign in_ready = a_en;

  assign out_valid = b_vld;
  assign out_sum   = b_sum;
  assign out_cout  = b_cout;

`ifdef CARRY_SKIP_PIPE_SUB_EN
  logic a_sub;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sub <= 1'b0;
    end else if (a_en && in_valid) begin
      a_sub <= in_sub;
    end
  end

  // Two's-complement subtract: a + ~b + 1; cout=1 means no borrow.
  assign add_b   = a_sub ? ~a_b : a_b;
  assign add_cin = a_sub ? 1'b1 : a_cin;
`else
  assign add_b   = a_b;
  assign add_cin = a_cin;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_vld <= 1'b0;
      a_a   <= '0;
      a_b   <= '0;
      a_cin <= 1'b0;
    end else if (a_en) begin
      a_vld <= in_valid;
      if (in_valid) begin
        a_a   <= in_a;
        a_b   <= in_b;
        a_cin <= in_cin;
      end
    end
  end

  carry_skip_generic #(
    .N(N)
  ) u_adder (
    .a   (a_a),
    .b   (add_b),
    .cin (add_cin),
    .sum (add_sum),
    .cout(add_cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b_vld  <= 1'b0;
      b_sum  <= '0;
      b_cout <= 1'b0;
    end else if (b_en) begin
      b_vld <= a_vld;
      if (a_vld) begin
        b_sum  <= add_sum;
        b_cout <= add_cout;
      end
    end
  end

endmodule

// File: tb/tb_carry_skip_pipe_stage.sv
// Self-checking bench for carry_skip_pipe_stage: random and directed beats
// checked against an arithmetic reference model and an in-order queue.
module tb_carry_skip_pipe_stage;

`ifdef CARRY_SKIP_PIPE_SUB_EN
  localparam int unsigned N = 16;
`else
  localparam int unsigned N = 64;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] in_a = '0;
  logic [N-1:0] in_b = '0;
  logic         in_cin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [N-1:0] out_sum;
  logic         out_cout;
`ifdef CARRY_SKIP_PIPE_SUB_EN
  logic         in_sub = 1'b0;
`endif

  int errors = 0;
  int checks = 0;

  // Per-cycle samples taken by step().
  logic         s_in_ready, s_out_valid, s_cout, fire_in, fire_out;
  logic [N-1:0] s_sum;
  logic [N:0]   exp_q[$];
  logic [N:0]   exp_v;

  always #5 clk = ~clk;

  carry_skip_pipe_stage #(
    .N(N)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_cin   (in_cin),
`ifdef CARRY_SKIP_PIPE_SUB_EN
    .in_sub   (in_sub),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .out_cout (out_cout)
  );

  // {cout, sum} of one beat, straight from the arithmetic definition.
  function automatic logic [N:0] model(input logic [N-1:0] a, input logic [N-1:0] b,
                                       input logic c, input logic s);
    logic [N:0] r;
    if (s) begin
      r[N]     = (a >= b);
      r[N-1:0] = a - b;
    end else begin
      r = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, c};
    end
    return r;
  endfunction

  function automatic logic [N-1:0] rnd();
    logic [N-1:0] r;
    r = '0;
    for (int i = 0; i < int'(N); i += 32) r = (r << 32) | N'($urandom);
    return r;
  endfunction

  // Drive one cycle's inputs mid-cycle and sample what the coming edge will do.
  task automatic step(input logic v, input logic [N-1:0] a, input logic [N-1:0] b,
                      input logic c, input logic s, input logic r);
    @(negedge clk);
    in_valid  = v;
    in_a      = a;
    in_b      = b;
    in_cin    = c;
`ifdef CARRY_SKIP_PIPE_SUB_EN
    in_sub    = s;
`endif
    out_ready = r;
    #1;
    s_in_ready  = in_ready;
    s_out_valid = out_valid;
    s_sum       = out_sum;
    s_cout      = out_cout;
    fire_in     = v && in_ready;
    fire_out    = out_valid && r;
    if (fire_in) exp_q.push_back(model(a, b, c, s));
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #2;
    checks++;
    if (out_valid !== 1'b0 || out_sum !== '0 || out_cout !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got vld=%b sum=%h cout=%b want 0/0/0",
               out_valid, out_sum, out_cout);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready got=%b want=1", in_ready);
    end
  endtask

  task automatic test_single();
    int acc_cyc, out_cyc;
    logic [N-1:0] ones;
    ones    = '1;
    acc_cyc = -1;
    out_cyc = -1;
    for (int cyc = 0; cyc < 8; cyc++) begin
      step(cyc == 0, ones, N'(1), 1'b0, 1'b0, 1'b1);
      if (fire_in) acc_cyc = cyc;
      if (s_out_valid && out_cyc < 0) begin
        out_cyc = cyc;
        void'(exp_q.pop_front());
        checks++;
        if (s_sum !== '0 || s_cout !== 1'b1) begin
          errors++;
          $display("FAIL single_result got sum=%h cout=%b want sum=0 cout=1", s_sum, s_cout);
        end
      end
    end
    checks++;
    if (acc_cyc != 0 || out_cyc != 2) begin
      errors++;
      $display("FAIL single_latency got accept=%0d out=%0d want 0/2", acc_cyc, out_cyc);
    end
  endtask

  task automatic test_stream();
    int bad_rdy, bad_vld, bad_data, n_out;
    logic s;
    bad_rdy = 0; bad_vld = 0; bad_data = 0; n_out = 0;
    for (int cyc = 0; cyc < 102; cyc++) begin
`ifdef CARRY_SKIP_PIPE_SUB_EN
      s = 1'($urandom);
`else
      s = 1'b0;
`endif
      step(cyc < 100, rnd(), rnd(), 1'($urandom), s, 1'b1);
      if (cyc < 100 && s_in_ready !== 1'b1) bad_rdy++;
      if (s_out_valid !== (cyc >= 2)) bad_vld++;
      if (fire_out) begin
        n_out++;
        if (exp_q.size() == 0) bad_data++;
        else begin
          exp_v = exp_q.pop_front();
          if ({s_cout, s_sum} !== exp_v) begin
            bad_data++;
            $display("FAIL stream_data got=%h want=%h", {s_cout, s_sum}, exp_v);
          end
        end
      end
    end
    checks++;
    if (bad_rdy != 0) begin
      errors++;
      $display("FAIL stream_in_ready got %0d low cycles want 0", bad_rdy);
    end
    checks++;
    if (bad_vld != 0) begin
      errors++;
      $display("FAIL stream_out_valid got %0d wrong cycles want 0", bad_vld);
    end
    checks++;
    if (bad_data != 0 || n_out != 100) begin
      errors++;
      $display("FAIL stream_results got bad=%0d count=%0d want 0/100", bad_data, n_out);
    end
  endtask

  task automatic test_backpressure();
    int idx, n_out, bad;
    idx = 0; n_out = 0; bad = 0;
    for (int cyc = 0; cyc < 5; cyc++) begin
      step(1'b1, N'(idx + 1), N'(10), 1'b0, 1'b0, 1'b0);
      if (fire_in) idx++;
      if (cyc >= 2 && (s_in_ready !== 1'b0 || s_out_valid !== 1'b1 || s_sum !== N'(11)))
        bad++;
    end
    checks++;
    if (idx != 2) begin
      errors++;
      $display("FAIL bp_accepted got=%0d want=2", idx);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL bp_stall got %0d bad cycles want 0 (in_ready=0, sum=11 held)", bad);
    end
    for (int cyc = 0; cyc < 10; cyc++) begin
      step(idx < 3, N'(idx + 1), N'(10), 1'b0, 1'b0, 1'b1);
      if (fire_in) idx++;
      if (fire_out) begin
        n_out++;
        checks++;
        if (s_sum !== N'(10 + n_out) || s_cout !== 1'b0) begin
          errors++;
          $display("FAIL bp_drain got=%0d want=%0d", s_sum, 10 + n_out);
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
    end
    checks++;
    if (idx != 3 || n_out != 3) begin
      errors++;
      $display("FAIL bp_counts got accepted=%0d emitted=%0d want 3/3", idx, n_out);
    end
  endtask

  task automatic test_simultaneous();
    logic [N-1:0] a[3];
    int n_out, bad;
    for (int i = 0; i < 3; i++) a[i] = rnd();
    n_out = 0; bad = 0;
    step(1'b1, a[0], N'(3), 1'b0, 1'b0, 1'b0);
    step(1'b1, a[1], N'(3), 1'b1, 1'b0, 1'b0);
    // Pipe is now full; pop and push on the same edge.
    step(1'b1, a[2], N'(5), 1'b0, 1'b0, 1'b1);
    checks++;
    if (fire_in !== 1'b1 || fire_out !== 1'b1) begin
      errors++;
      $display("FAIL simul_both_fire got in=%b out=%b want 1/1", fire_in, fire_out);
    end
    if (fire_out) begin
      exp_v = exp_q.pop_front();
      n_out++;
      if ({s_cout, s_sum} !== exp_v) bad++;
    end
    for (int cyc = 0; cyc < 8; cyc++) begin
      step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
      if (fire_out) begin
        n_out++;
        if (exp_q.size() == 0) bad++;
        else begin
          exp_v = exp_q.pop_front();
          if ({s_cout, s_sum} !== exp_v) bad++;
        end
      end
    end
    checks++;
    if (bad != 0 || n_out != 3 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL simul_results got bad=%0d count=%0d left=%0d want 0/3/0",
               bad, n_out, exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    int stale, got;
    stale = 0; got = 0;
    step(1'b1, N'(100), N'(1), 1'b0, 1'b0, 1'b0);
    step(1'b1, N'(200), N'(2), 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_sum !== '0) begin
      errors++;
      $display("FAIL midreset_async got vld=%b sum=%h want 0/0", out_valid, out_sum);
    end
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    for (int cyc = 0; cyc < 4; cyc++) begin
      step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
      if (s_out_valid !== 1'b0) stale++;
    end
    checks++;
    if (stale != 0) begin
      errors++;
      $display("FAIL midreset_stale got %0d valid cycles want 0", stale);
    end
    step(1'b1, N'(7), N'(8), 1'b1, 1'b0, 1'b1);
    for (int cyc = 0; cyc < 6; cyc++) begin
      step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
      if (fire_out) begin
        got++;
        checks++;
        if (s_sum !== N'(16) || s_cout !== 1'b0) begin
          errors++;
          $display("FAIL midreset_beat got sum=%0d cout=%b want 16/0", s_sum, s_cout);
        end
      end
    end
    exp_q.delete();
    checks++;
    if (got != 1) begin
      errors++;
      $display("FAIL midreset_count got=%0d want=1", got);
    end
  endtask

`ifdef CARRY_SKIP_PIPE_SUB_EN
  task automatic test_sub();
    int got;
    logic [N:0] want[2];
    want[0] = {1'b0, 16'hFFFE};
    want[1] = {1'b1, 16'h0005};
    got = 0;
    step(1'b1, N'(5), N'(7), 1'b0, 1'b1, 1'b1);
    step(1'b1, N'(9), N'(4), 1'b1, 1'b1, 1'b1);
    for (int cyc = 0; cyc < 6; cyc++) begin
      step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
      if (fire_out && got < 2) begin
        checks++;
        if ({s_cout, s_sum} !== want[got]) begin
          errors++;
          $display("FAIL sub_%0d got=%h want=%h", got, {s_cout, s_sum}, want[got]);
        end
        got++;
      end
    end
    exp_q.delete();
    checks++;
    if (got != 2) begin
      errors++;
      $display("FAIL sub_count got=%0d want=2", got);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_stream();
    test_backpressure();
    test_simultaneous();
    test_reset_mid();
`ifdef CARRY_SKIP_PIPE_SUB_EN
    test_sub();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
